alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_issue_ctrl_if.sv | 53 +++++
 rtl/alu_lat_counter.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
`timescale 1ns/1ps
package alu_pkg;

    localparam int ALU_N = 8;

    localparam logic [3:0] CMD_MUL_INC = 4'd9;
    localparam logic [3:0] CMD_MUL_SHL = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        BEAT_A,
        GAP,
        BEAT_B,
        WAIT,
        HOLD
    } state_t;

    typedef struct packed {
        logic oflow;
        logic cout;
        logic g;
        logic e;
        logic l;
        logic err;
    } flags_t;

    function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
        return mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the issue controller.
`timescale 1ns/1ps
interface alu_issue_ctrl_if #(
    parameter int N = 8
);
    logic           req_valid;
    logic           req_ready;
    logic           req_mode;
    logic [3:0]     req_cmd;
    logic [N-1:0]   req_opa;
    logic [N-1:0]   req_opb;
    logic           req_cin;
    logic           req_split;

    logic [1:0]     alu_inp_valid;
    logic           alu_mode;
    logic [3:0]     alu_cmd;
    logic [N-1:0]   alu_opa;
    logic [N-1:0]   alu_opb;
    logic           alu_cin;
    logic [2*N-1:0] alu_res;
    logic           alu_oflow;
    logic           alu_cout;
    logic           alu_g;
    logic           alu_e;
    logic           alu_l;
    logic           alu_err;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*N-1:0] rsp_res;
    logic [5:0]     rsp_flags;

    // environment side: issues requests, models the ALU, consumes responses
    modport master (
        output req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split,
        input  req_ready,
        input  alu_inp_valid, alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin,
        output alu_res, alu_oflow, alu_cout, alu_g, alu_e, alu_l, alu_err,
        input  rsp_valid, rsp_res, rsp_flags,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split,
        output req_ready,
        output alu_inp_valid, alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin,
        input  alu_res, alu_oflow, alu_cout, alu_g, alu_e, alu_l, alu_err,
        output rsp_valid, rsp_res, rsp_flags,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_lat_counter.sv
// Loadable down-counter with clock enable and zero flag; saturates at zero.
`timescale 1ns/1ps
module alu_lat_counter #(
    parameter int W = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (ce) begin
            if (load) begin
                count <= load_val;
            end else if (dec && count != '0) begin
                count <= count - W'(1);
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the ALU: sequences operand beats, waits the
// command latency, then holds the captured result until it is consumed.
//
//   state  | meaning
//   IDLE   | ready for a request
//   BEAT_A | OPA beat of a split op (inp_valid 01)
//   GAP    | idle cycles between split beats
//   BEAT_B | final operand beat (inp_valid 11 or 10)
//   WAIT   | ALU latency countdown
//   HOLD   | response valid, waiting for rsp_ready
`timescale 1ns/1ps
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int N         = ALU_N,
    parameter int LAT_NORM  = 1,
    parameter int LAT_MUL   = 2,
    parameter int SPLIT_GAP = 2
)(
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    alu_issue_ctrl_if.slave bus
);

    // Counter holds the cycles remaining after the current one, so a phase of
    // length L is loaded with L-1 and ends in the cycle the counter reads zero.
    localparam logic [3:0] GAP_LOAD  = (SPLIT_GAP > 0) ? 4'(SPLIT_GAP - 1) : 4'd0;
    localparam logic [3:0] NORM_LOAD = (LAT_NORM > 0)  ? 4'(LAT_NORM - 1)  : 4'd0;
    localparam logic [3:0] MUL_LOAD  = (LAT_MUL > 0)   ? 4'(LAT_MUL - 1)   : 4'd0;

    state_t         state, state_n;
    logic           req_ready_q, req_ready_n;
    logic [1:0]     iv_q, iv_n;
    logic           mode_q, mode_n;
    logic [3:0]     cmd_q, cmd_n;
    logic [N-1:0]   opa_q, opa_n;
    logic [N-1:0]   opb_q, opb_n;
    logic           cin_q, cin_n;
    logic [N-1:0]   op_opb_q, op_opb_n;
    logic           rsp_valid_q, rsp_valid_n;
    logic [2*N-1:0] rsp_res_q, rsp_res_n;
    flags_t         rsp_flags_q, rsp_flags_n;

    logic           cnt_load;
    logic [3:0]     cnt_val;
    logic           cnt_dec;
    logic           cnt_zero;

    alu_lat_counter #(.W(4)) u_cnt (
        .clk      (CLK),
        .rst      (RST),
        .ce       (CE),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
            iv_q        <= 2'b00;
            mode_q      <= 1'b0;
            cmd_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            cin_q       <= 1'b0;
            op_opb_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else if (CE) begin
            state       <= state_n;
            req_ready_q <= req_ready_n;
            iv_q        <= iv_n;
            mode_q      <= mode_n;
            cmd_q       <= cmd_n;
            opa_q       <= opa_n;
            opb_q       <= opb_n;
            cin_q       <= cin_n;
            op_opb_q    <= op_opb_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_res_q   <= rsp_res_n;
            rsp_flags_q <= rsp_flags_n;
        end
    end

    always_comb begin
        state_n     = state;
        iv_n        = 2'b00;
        mode_n      = mode_q;
        cmd_n       = cmd_q;
        opa_n       = opa_q;
        opb_n       = opb_q;
        cin_n       = cin_q;
        op_opb_n    = op_opb_q;
        rsp_valid_n = rsp_valid_q;
        rsp_res_n   = rsp_res_q;
        rsp_flags_n = rsp_flags_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        cnt_dec     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    mode_n   = bus.req_mode;
                    cmd_n    = bus.req_cmd;
                    opa_n    = bus.req_opa;
                    cin_n    = bus.req_cin;
                    op_opb_n = bus.req_opb;
                    if (bus.req_split) begin
                        state_n = BEAT_A;
                        iv_n    = 2'b01;
                        opb_n   = '0;
                    end else begin
                        state_n = BEAT_B;
                        iv_n    = 2'b11;
                        opb_n   = bus.req_opb;
                    end
                end
            end
            BEAT_A: begin
                if (SPLIT_GAP == 0) begin
                    state_n = BEAT_B;
                    iv_n    = 2'b10;
                    opb_n   = op_opb_q;
                end else begin
                    state_n  = GAP;
                    cnt_load = 1'b1;
                    cnt_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    state_n = BEAT_B;
                    iv_n    = 2'b10;
                    opb_n   = op_opb_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            BEAT_B: begin
                state_n  = WAIT;
                cnt_load = 1'b1;
                cnt_val  = is_mul(mode_q, cmd_q) ? MUL_LOAD : NORM_LOAD;
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_n     = HOLD;
                    rsp_valid_n = 1'b1;
                    rsp_res_n   = bus.alu_res;
                    rsp_flags_n = {bus.alu_oflow, bus.alu_cout, bus.alu_g,
                                   bus.alu_e, bus.alu_l, bus.alu_err};
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        req_ready_n = (state_n == IDLE);
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.alu_inp_valid = iv_q;
    assign bus.alu_mode      = mode_q;
    assign bus.alu_cmd       = cmd_q;
    assign bus.alu_opa       = opa_q;
    assign bus.alu_opb       = opb_q;
    assign bus.alu_cin       = cin_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_res       = rsp_res_q;
    assign bus.rsp_flags     = rsp_flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vectors, corner sequences and random ops
// checked against a cycle-budget/ALU-function reference model.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    localparam int N  = 8;
    localparam int LN = 1;
    localparam int LM = 2;
    localparam int G  = 2;

    logic clk;
    logic rst;
    logic ce;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl_if #(.N(N)) bus ();

    alu_issue_ctrl #(
        .N(N), .LAT_NORM(LN), .LAT_MUL(LM), .SPLIT_GAP(G)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .CE  (ce),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference: ALU function and op timing ----------------
    function automatic logic [21:0] alu_fn(input logic m, input logic [3:0] c,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic ci);
        logic [15:0] r;
        logic [7:0]  s;
        logic        err;
        logic        cout;
        r = '0; err = 1'b0; s = a << 1;
        if (c > 4'd12) err = 1'b1;
        else if (m) begin
            case (c)
                4'd0:    r = 16'(a) + 16'(b);
                4'd1:    r = 16'(a) - 16'(b);
                4'd2:    r = 16'(a) + 16'(b) + 16'(ci);
                4'd9:    r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
                4'd10:   r = 16'(s) * 16'(b);
                default: r = {a, b};
            endcase
        end else begin
            case (c)
                4'd0:    r = {8'h00, a & b};
                4'd1:    r = {8'h00, a | b};
                4'd2:    r = {8'h00, a ^ b};
                default: r = {a, b};
            endcase
        end
        cout = (m && (c == 4'd0 || c == 4'd2)) ? r[8] : 1'b0;
        return {1'b0, cout, a > b, a == b, a < b, err, r};
    endfunction

    function automatic int alu_lat(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? LM : LN;
    endfunction

    function automatic int ref_lat(input logic sp, input logic m, input logic [3:0] c);
        return (sp ? 3 + G : 2) + alu_lat(m, c);
    endfunction

    function automatic logic [1:0] exp_iv(input logic sp, input int c);
        if (!sp) return (c == 1) ? 2'b11 : 2'b00;
        if (c == 1) return 2'b01;
        if (c == 2 + G) return 2'b10;
        return 2'b00;
    endfunction

    // ---------------- ALU stand-in: result valid only in its latency cycle ----
    logic [7:0]  a_lat;
    logic [21:0] pend;
    int          rem;
    logic [21:0] fn_v;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= 0;
            {bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_e, bus.alu_l, bus.alu_err} <= 6'b110110;
            bus.alu_res <= 16'hDEAD;
        end else if (ce) begin
            {bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_e, bus.alu_l, bus.alu_err} <= 6'b110110;
            bus.alu_res <= 16'hDEAD;
            if (bus.alu_inp_valid[0]) a_lat <= bus.alu_opa;
            if (bus.alu_inp_valid[1]) begin
                fn_v = alu_fn(bus.alu_mode, bus.alu_cmd,
                              bus.alu_inp_valid[0] ? bus.alu_opa : a_lat,
                              bus.alu_opb, bus.alu_cin);
                if (alu_lat(bus.alu_mode, bus.alu_cmd) <= 1) begin
                    {bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_e, bus.alu_l, bus.alu_err, bus.alu_res} <= fn_v;
                    rem <= 0;
                end else begin
                    pend <= fn_v;
                    rem  <= alu_lat(bus.alu_mode, bus.alu_cmd) - 1;
                end
            end else if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1)
                    {bus.alu_oflow, bus.alu_cout, bus.alu_g, bus.alu_e, bus.alu_l, bus.alu_err, bus.alu_res} <= pend;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic m, input logic [3:0] c, input logic [7:0] a,
                             input logic [7:0] b, input logic ci, input logic sp);
        bus.req_valid = 1'b1;
        bus.req_mode  = m;
        bus.req_cmd   = c;
        bus.req_opa   = a;
        bus.req_opb   = b;
        bus.req_cin   = ci;
        bus.req_split = sp;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_alu_bus"}, {bus.alu_inp_valid, bus.alu_mode, bus.alu_cmd,
                                bus.alu_opa, bus.alu_opb, bus.alu_cin}, 32'd0);
        chk({tag, "_rsp_data"}, {10'd0, bus.rsp_flags, bus.rsp_res}, 32'd0);
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (!bus.rsp_valid && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_rsp_timeout"}, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_rsp_release"}, {bus.rsp_valid, bus.req_ready}, 32'b01);
    endtask

    task automatic run_op(input string tag, input logic m, input logic [3:0] c,
                          input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sp, input logic [15:0] eres, input logic [5:0] eflg,
                          input int elat, input int hold);
        int         k;
        logic [1:0] ive;
        logic       ok;
        drive_req(m, c, a, b, ci, sp);
        k = 0;
        while (!bus.req_ready && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        ok = 1'b1;
        k  = 1;
        while (!bus.rsp_valid && k < 40) begin
            ive = exp_iv(sp, k);
            if (bus.alu_inp_valid !== ive) ok = 1'b0;
            if (ive != 2'b00 && {bus.alu_mode, bus.alu_cmd, bus.alu_cin} !== {m, c, ci}) ok = 1'b0;
            if (ive[0] && bus.alu_opa !== a) ok = 1'b0;
            if (ive == 2'b01 && bus.alu_opb !== 8'h00) ok = 1'b0;
            if (ive[1] && bus.alu_opb !== b) ok = 1'b0;
            if (bus.req_ready !== 1'b0) ok = 1'b0;
            tick();
            k++;
        end
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, "_latency"}, 32'(k), 32'(elat));
        chk({tag, "_beats"}, 32'(ok), 32'd1);
        chk({tag, "_rsp_res"}, 32'(bus.rsp_res), 32'(eres));
        chk({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 32'(eflg));
        ok = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== eres || bus.req_ready !== 1'b0) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, 32'(ok), 32'd1);
        handshake(tag);
    endtask

    typedef struct {
        logic        m;
        logic [3:0]  c;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci;
        logic        sp;
        logic [15:0] res;
        logic [5:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic        m, ci, sp;
        logic [3:0]  c;
        logic [7:0]  a, b;
        logic [21:0] r;

        vecs[0] = '{1'b1, 4'd0,  8'h0F, 8'h01, 1'b0, 1'b0, 16'h0010, 6'b001000, 3};
        vecs[1] = '{1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 1'b1, 16'h0030, 6'b001000, 6};
        vecs[2] = '{1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 1'b0, 16'h0014, 6'b000010, 4};
        vecs[3] = '{1'b1, 4'd10, 8'h05, 8'h06, 1'b0, 1'b0, 16'h003C, 6'b000010, 4};
        vecs[4] = '{1'b1, 4'd14, 8'hAA, 8'h55, 1'b0, 1'b0, 16'h0000, 6'b001001, 3};
        vecs[5] = '{1'b0, 4'd9,  8'h12, 8'h12, 1'b0, 1'b0, 16'h1212, 6'b000100, 3};
        vecs[6] = '{1'b1, 4'd10, 8'h07, 8'h09, 1'b0, 1'b1, 16'h007E, 6'b000010, 7};
        vecs[7] = '{1'b1, 4'd2,  8'hFF, 8'h02, 1'b1, 1'b0, 16'h0102, 6'b011000, 3};

        rst = 1'b1;
        ce  = 1'b1;
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].c, vecs[i].a, vecs[i].b,
                   vecs[i].ci, vecs[i].sp, vecs[i].res, vecs[i].flg, vecs[i].lat, i % 3);

        // backpressure with a second request pending
        drive_req(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 1'b0);
        tick();
        drive_req(1'b0, 4'd1, 8'h0F, 8'hA0, 1'b0, 1'b0);
        wait_rsp("bp");
        chk("bp_first_res", 32'(bus.rsp_res), 32'h0010);
        ok = 1'b1;
        for (int h = 0; h < 5; h++) begin
            tick();
            if (bus.rsp_res !== 16'h0010 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'd1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_no_accept_in_hold", {bus.alu_inp_valid, bus.req_ready, bus.rsp_valid}, 32'b0010);
        tick();
        bus.req_valid = 1'b0;
        chk("bp_second_accept", {bus.alu_inp_valid, bus.req_ready, bus.alu_opb}, {22'd0, 2'b11, 1'b0, 8'hA0});
        wait_rsp("bp2");
        chk("bp_second_res", 32'(bus.rsp_res), 32'h00AF);
        handshake("bp2");

        // clock enable low during GAP
        drive_req(1'b0, 4'd0, 8'hF0, 8'h3C, 1'b0, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        chk("ce_beat_a", 32'(bus.alu_inp_valid), 32'b01);
        tick();
        chk("ce_gap1", 32'(bus.alu_inp_valid), 32'b00);
        ce = 1'b0;
        ok = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            if (bus.alu_inp_valid !== 2'b00 || bus.req_ready !== 1'b0) ok = 1'b0;
        end
        chk("ce_frozen", 32'(ok), 32'd1);
        ce = 1'b1;
        tick();
        chk("ce_gap2", 32'(bus.alu_inp_valid), 32'b00);
        tick();
        chk("ce_beat_b", {bus.alu_inp_valid, bus.alu_opb}, {2'b10, 8'h3C});
        wait_rsp("ce");
        chk("ce_res", 32'(bus.rsp_res), 32'h0030);
        handshake("ce");

        // request presented while CE is low is not taken
        ce = 1'b0;
        drive_req(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 1'b0);
        tick();
        tick();
        ce = 1'b1;
        chk("ce_no_accept", 32'(bus.alu_inp_valid), 32'b00);
        tick();
        bus.req_valid = 1'b0;
        chk("ce_late_accept", 32'(bus.alu_inp_valid), 32'b11);
        wait_rsp("ce2");
        chk("ce2_res", 32'(bus.rsp_res), 32'h0010);
        handshake("ce2");

        // reset during WAIT
        drive_req(1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 1'b0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        tick();
        rst = 1'b0;
        ok = 1'b1;
        for (int h = 0; h < 6; h++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.alu_inp_valid !== 2'b00) ok = 1'b0;
        end
        chk("rst_no_rsp", 32'(ok), 32'd1);
        run_op("post_rst", 1'b1, 4'd9, 8'h03, 8'h04, 1'b0, 1'b0, 16'h0014, 6'b000010, 4, 0);

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            m  = 1'($urandom_range(0, 1));
            c  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 4'd9 : 4'd10)
                                              : 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom_range(0, 1));
            sp = 1'($urandom_range(0, 1));
            r  = alu_fn(m, c, a, b, ci);
            run_op($sformatf("rnd%0d", i), m, c, a, b, ci, sp, r[15:0], r[21:16],
                   ref_lat(sp, m, c), $urandom_range(0, 3));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
